// File: rtl/conv_filter_pkg.sv
// conv_filter_pkg: shared constants and types for the 3x3 stream filter.
package conv_filter_pkg;

    localparam int DEF_PIX_W  = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_MODE_W = 3;

    // Depth of the arithmetic pipeline, window register to pixel_out.
    localparam int LAT = 2;

    localparam logic [2:0] MODE_PASS    = 3'd0;
    localparam logic [2:0] MODE_GAUSS   = 3'd1;
    localparam logic [2:0] MODE_SHARPEN = 3'd2;
    localparam logic [2:0] MODE_SOBEL   = 3'd3;
    localparam logic [2:0] MODE_MAX     = 3'd4;
    localparam logic [2:0] MODE_MIN     = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Default-width 3x3 window, indexed [row][column].
    typedef logic [2:0][2:0][DEF_PIX_W-1:0] window_t;

endpackage

// File: rtl/conv3x3_datapath.sv
// conv3x3_datapath: two-stage arithmetic pipeline applying the selected
// kernel to a 3x3 window. Stage 1 holds sums, gradients and extrema;
// stage 2 holds the final combine/clamp together with valid, address, last.
module conv3x3_datapath
    import conv_filter_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MODE_W = DEF_MODE_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [2:0][2:0][PIX_W-1:0] win,
    input  logic [MODE_W-1:0]         mode,
    input  logic                      win_valid,
    input  logic                      win_last,
    input  logic [ADDR_W-1:0]         win_addr,
    output logic [PIX_W-1:0]          res_pixel,
    output logic                      res_valid,
    output logic [ADDR_W-1:0]         res_addr,
    output logic                      res_last
);

    // One extra bit beyond PIX_W+4 keeps the unnormalised Gaussian sum exact.
    localparam int INT_W = PIX_W + 5;

    function automatic logic signed [INT_W-1:0] widen(input logic [PIX_W-1:0] p);
        return signed'({{(INT_W-PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [PIX_W-1:0] clamp(input logic signed [INT_W-1:0] v);
        logic [PIX_W-1:0] r;
        if (v[INT_W-1]) begin
            r = '0;
        end else if (|v[INT_W-2:PIX_W]) begin
            r = '1;
        end else begin
            r = v[PIX_W-1:0];
        end
        return r;
    endfunction

    logic signed [INT_W-1:0] e_s [3][3];
    logic signed [INT_W-1:0] gauss_s, gx_s, gy_s, cross_s;
    logic [PIX_W-1:0]        max_s, min_s;

    logic signed [INT_W-1:0] gauss_r, gx_r, gy_r, cross_r;
    logic [PIX_W-1:0]        centre_r, max_r, min_r;
    logic [MODE_W-1:0]       mode1_r;
    logic                    valid1_r, last1_r;
    logic [ADDR_W-1:0]       addr1_r;

    logic signed [INT_W-1:0] centre_e_s, abs_gx_s, abs_gy_s;
    logic [PIX_W-1:0]        pixel_s;

    // Stage-1 combinational: weighted sums, Sobel gradients and window extrema.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                e_s[r][c] = widen(win[r][c]);
            end
        end
        gauss_s = e_s[0][0] + (e_s[0][1] <<< 1'b1) + e_s[0][2]
                + (e_s[1][0] <<< 1'b1) + (e_s[1][1] <<< 2'd2) + (e_s[1][2] <<< 1'b1)
                + e_s[2][0] + (e_s[2][1] <<< 1'b1) + e_s[2][2];
        gx_s = (e_s[0][2] + (e_s[1][2] <<< 1'b1) + e_s[2][2])
             - (e_s[0][0] + (e_s[1][0] <<< 1'b1) + e_s[2][0]);
        gy_s = (e_s[2][0] + (e_s[2][1] <<< 1'b1) + e_s[2][2])
             - (e_s[0][0] + (e_s[0][1] <<< 1'b1) + e_s[0][2]);
        cross_s = e_s[0][1] + e_s[1][0] + e_s[1][2] + e_s[2][1];
        max_s = win[0][0];
        min_s = win[0][0];
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                max_s = (win[r][c] > max_s) ? win[r][c] : max_s;
                min_s = (win[r][c] < min_s) ? win[r][c] : min_s;
            end
        end
    end

    // Stage-1 registers: partial results plus the tag fields travelling with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gauss_r  <= '0;
            gx_r     <= '0;
            gy_r     <= '0;
            cross_r  <= '0;
            centre_r <= '0;
            max_r    <= '0;
            min_r    <= '0;
            mode1_r  <= '0;
            valid1_r <= 1'b0;
            last1_r  <= 1'b0;
            addr1_r  <= '0;
        end else begin
            gauss_r  <= gauss_s;
            gx_r     <= gx_s;
            gy_r     <= gy_s;
            cross_r  <= cross_s;
            centre_r <= win[1][1];
            max_r    <= max_s;
            min_r    <= min_s;
            mode1_r  <= mode;
            valid1_r <= win_valid;
            last1_r  <= win_last;
            addr1_r  <= win_addr;
        end
    end

    // Stage-2 combinational: mode select, final combine and saturation.
    always_comb begin
        centre_e_s = widen(centre_r);
        abs_gx_s   = gx_r[INT_W-1] ? -gx_r : gx_r;
        abs_gy_s   = gy_r[INT_W-1] ? -gy_r : gy_r;
        case (mode1_r)
            MODE_W'(MODE_PASS):    pixel_s = centre_r;
            MODE_W'(MODE_GAUSS):   pixel_s = clamp(gauss_r >>> 3'd4);
            MODE_W'(MODE_SHARPEN): pixel_s = clamp((centre_e_s <<< 2'd2) + centre_e_s - cross_r);
            MODE_W'(MODE_SOBEL):   pixel_s = clamp(abs_gx_s + abs_gy_s);
            MODE_W'(MODE_MAX):     pixel_s = max_r;
            MODE_W'(MODE_MIN):     pixel_s = min_r;
            default:               pixel_s = centre_r;
        endcase
    end

    // Stage-2 registers: the block's registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_pixel <= '0;
            res_valid <= 1'b0;
            res_addr  <= '0;
            res_last  <= 1'b0;
        end else begin
            res_pixel <= valid1_r ? pixel_s : '0;
            res_valid <= valid1_r;
            res_addr  <= valid1_r ? addr1_r : '0;
            res_last  <= valid1_r & last1_r;
        end
    end

endmodule

// File: rtl/conv3x3_stream_filter.sv
// conv3x3_stream_filter: frame control, column counting and the sliding
// 3x3 window feeding the arithmetic pipeline.
module conv3x3_stream_filter
    import conv_filter_pkg::*;
#(
    parameter int PIX_W  = DEF_PIX_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int MODE_W = DEF_MODE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] size,
    input  logic [MODE_W-1:0] filter_mode,
    input  logic              valid_in,
    input  logic [PIX_W-1:0]  pixel_in1,
    input  logic [PIX_W-1:0]  pixel_in2,
    input  logic [PIX_W-1:0]  pixel_in3,
    output logic              busy,
    output logic              valid_out,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic [PIX_W-1:0]  pixel_out,
    output logic              done,
    output logic              size_err
);

    state_t                     state_r;
    logic [ADDR_W-1:0]          size_r, col_cnt_r, win_addr_r;
    logic [MODE_W-1:0]          mode_r;
    logic [2:0][2:0][PIX_W-1:0] win_r;
    logic                       win_valid_r, win_last_r;
    logic                       busy_r, size_err_r;
    logic [1:0]                 drain_cnt_r;

    logic accept_s, last_col_s, start_ok_s, dp_done_s;

    // Decode column acceptance, last-column position and start acceptance.
    always_comb begin
        accept_s   = ((state_r == ST_FILL) || (state_r == ST_RUN)) && valid_in;
        last_col_s = (col_cnt_r == (size_r - ADDR_W'(1)));
        // busy_r also blocks start during the done cycle, after DRAIN has exited.
        start_ok_s = (state_r == ST_IDLE) && start && !busy_r;
    end

    // Sliding window: shift left and load the new column on each accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_r <= '0;
        end else if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= win_r[r][2];
            end
            win_r[0][2] <= pixel_in1;
            win_r[1][2] <= pixel_in2;
            win_r[2][2] <= pixel_in3;
        end
    end

    // Frame FSM with column counter, window tags, busy and size_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            size_r      <= '0;
            mode_r      <= '0;
            col_cnt_r   <= '0;
            win_addr_r  <= '0;
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            size_err_r  <= 1'b0;
            drain_cnt_r <= 2'd0;
        end else begin
            size_err_r  <= 1'b0;
            win_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
            if (dp_done_s) begin
                busy_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_ok_s) begin
                        if (size < ADDR_W'(3)) begin
                            size_err_r <= 1'b1;
                        end else begin
                            size_r    <= size;
                            mode_r    <= filter_mode;
                            col_cnt_r <= '0;
                            busy_r    <= 1'b1;
                            state_r   <= ST_FILL;
                        end
                    end
                end
                ST_FILL, ST_RUN: begin
                    if (accept_s) begin
                        col_cnt_r   <= col_cnt_r + ADDR_W'(1);
                        win_addr_r  <= col_cnt_r - ADDR_W'(1);
                        win_valid_r <= (col_cnt_r >= ADDR_W'(2));
                        win_last_r  <= last_col_s;
                        if (last_col_s) begin
                            drain_cnt_r <= 2'd0;
                            state_r     <= ST_DRAIN;
                        end else if (col_cnt_r == ADDR_W'(1)) begin
                            state_r <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == 2'(LAT - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        drain_cnt_r <= drain_cnt_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    conv3x3_datapath #(
        .PIX_W  (PIX_W),
        .ADDR_W (ADDR_W),
        .MODE_W (MODE_W)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .win       (win_r),
        .mode      (mode_r),
        .win_valid (win_valid_r),
        .win_last  (win_last_r),
        .win_addr  (win_addr_r),
        .res_pixel (pixel_out),
        .res_valid (valid_out),
        .res_addr  (pixel_addr),
        .res_last  (dp_done_s)
    );

    assign done     = dp_done_s;
    assign busy     = busy_r;
    assign size_err = size_err_r;

endmodule

// File: tb/tb_conv3x3_stream_filter.sv
// tb_conv3x3_stream_filter: randomized frames checked against a kernel-table
// reference model, plus directed border, bubble, restart and reset cases.
module tb_conv3x3_stream_filter;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 8;
    localparam int MODE_W = 3;

    localparam int GAUSS_K [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};
    localparam int SOBEL_X [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    localparam int SOBEL_Y [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] size = '0;
    logic [MODE_W-1:0] filter_mode = '0;
    logic              valid_in = 1'b0;
    logic [PIX_W-1:0]  pixel_in1 = '0, pixel_in2 = '0, pixel_in3 = '0;
    logic              busy, valid_out, done, size_err;
    logic [ADDR_W-1:0] pixel_addr;
    logic [PIX_W-1:0]  pixel_out;

    conv3x3_stream_filter dut (
        .clk(clk), .rst(rst), .start(start), .size(size), .filter_mode(filter_mode),
        .valid_in(valid_in), .pixel_in1(pixel_in1), .pixel_in2(pixel_in2), .pixel_in3(pixel_in3),
        .busy(busy), .valid_out(valid_out), .pixel_addr(pixel_addr), .pixel_out(pixel_out),
        .done(done), .size_err(size_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int addr;
        int pix;
        int last;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   px [0:255][0:2];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   res_cnt = 0;
    int   last_pix = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference: apply the kernel definitions to the window centred on column c.
    function automatic int ref_pix(input int mode, input int c);
        int w [3][3];
        int acc, gx, gy, r;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = px[c - 1 + j][i];
        acc = 0; gx = 0; gy = 0;
        case (mode)
            1: begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        acc += GAUSS_K[i][j] * w[i][j];
                r = acc / 16;
            end
            2: r = 5 * w[1][1] - w[0][1] - w[1][0] - w[1][2] - w[2][1];
            3: begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++) begin
                        gx += SOBEL_X[i][j] * w[i][j];
                        gy += SOBEL_Y[i][j] * w[i][j];
                    end
                r = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
            end
            4: begin
                r = 0;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (w[i][j] > r) r = w[i][j];
            end
            5: begin
                r = 255;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        if (w[i][j] < r) r = w[i][j];
            end
            default: r = w[1][1];
        endcase
        if (r < 0) r = 0;
        if (r > 255) r = 255;
        return r;
    endfunction

    // Output monitor: every result must match the next expected entry in order.
    always @(negedge clk) begin
        if (!rst && valid_out) begin
            if (exp_q.size() == 0) begin
                check_value("unexpected_valid", int'(valid_out), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_value("pixel_addr", int'(pixel_addr), mon_e.addr);
                check_value("pixel_out", int'(pixel_out), mon_e.pix);
                check_value("done_flag", int'(done), mon_e.last);
                check_value("latency", cyc, mon_e.cyc);
                res_cnt++;
                last_pix = int'(pixel_out);
            end
        end else if (!rst && done) begin
            check_value("done_without_valid", int'(done), 0);
        end
    end

    // pat: 0 random, 1 extremes, 2 all tens, 3 directed three-column image.
    task automatic run_frame(input int sz, input int md, input int pat, input int bubble_pct,
                             input int gap_col, input int restart_col, input int abort_col);
        int got_done;
        for (int c = 0; c < sz; c++)
            for (int r = 0; r < 3; r++) begin
                case (pat)
                    1: px[c][r] = ($urandom_range(0, 1) == 0) ? 0 :
                                  (($urandom_range(0, 1) == 0) ? 255 : int'($urandom_range(0, 255)));
                    2: px[c][r] = 10;
                    3: px[c][r] = (c == 0) ? 147 : (c == 1) ? ((r == 1) ? 150 : 149)
                                : ((r == 0) ? 19 : (r == 1) ? 41 : 52);
                    default: px[c][r] = int'($urandom_range(0, 255));
                endcase
            end
        res_cnt = 0;
        start = 1'b1; size = ADDR_W'(sz); filter_mode = MODE_W'(md);
        @(posedge clk); #1;
        start = 1'b0;
        check_value("busy_after_start", int'(busy), 1);
        for (int c = 0; c < sz; c++) begin
            if (c == abort_col) begin
                rst = 1'b1;
                #1;
                check_value("abort_outputs",
                            int'({busy, valid_out, done, size_err, pixel_addr, pixel_out}), 0);
                exp_q.delete();
                repeat (2) @(posedge clk);
                #1;
                rst = 1'b0;
                valid_in = 1'b0;
                return;
            end
            while ((c == gap_col) || (int'($urandom_range(0, 99)) < bubble_pct)) begin
                valid_in = 1'b0;
                pixel_in1 = PIX_W'($urandom); pixel_in2 = PIX_W'($urandom); pixel_in3 = PIX_W'($urandom);
                @(posedge clk); #1;
                if (c == gap_col) begin
                    @(posedge clk); #1;
                    break;
                end
            end
            valid_in = 1'b1;
            pixel_in1 = PIX_W'(px[c][0]); pixel_in2 = PIX_W'(px[c][1]); pixel_in3 = PIX_W'(px[c][2]);
            if (c == restart_col) begin
                start = 1'b1; size = ADDR_W'(3); filter_mode = MODE_W'((md + 1) % 6);
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (c >= 2) begin
                exp_t e;
                e.addr = c - 1;
                e.pix  = ref_pix(md, c - 1);
                e.last = (c == sz - 1) ? 1 : 0;
                e.cyc  = cyc + 2;
                exp_q.push_back(e);
            end
        end
        valid_in = 1'b0;
        got_done = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
        end
        check_value("done_seen", got_done, 1);
        @(negedge clk);
        check_value("busy_after_done", int'(busy), 0);
        check_value("result_count", res_cnt, sz - 2);
        check_value("queue_drained", exp_q.size(), 0);
    endtask

    int plan_modes [6] = '{1, 0, 2, 3, 4, 5};
    int plan_exp   [6] = '{121, 150, 255, 255, 150, 19};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_value("reset_outputs",
                    int'({busy, valid_out, done, size_err, pixel_addr, pixel_out}), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed three-column image through every kernel.
        for (int i = 0; i < 6; i++) begin
            run_frame(3, plan_modes[i], 3, 0, -1, -1, -1);
            check_value("plan_pixel", last_pix, plan_exp[i]);
        end

        // Flat image through Sobel with a two-cycle gap mid-frame.
        run_frame(6, 3, 2, 0, 3, -1, -1);

        // Undersized starts: size_err pulse only, valid_in ignored in IDLE.
        for (int s = 0; s < 3; s++) begin
            start = 1'b1; size = ADDR_W'(s); filter_mode = '0; valid_in = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check_value("size_err_pulse", int'(size_err), 1);
            check_value("size_err_busy", int'(busy), 0);
            @(posedge clk); #1;
            check_value("size_err_cleared", int'(size_err), 0);
            repeat (3) begin
                @(posedge clk); #1;
            end
            valid_in = 1'b0;
            check_value("idle_busy", int'(busy), 0);
        end

        // Start during a running frame is ignored.
        run_frame(8, 1, 0, 0, -1, 4, -1);

        // Reset after four columns, then a normal short frame.
        run_frame(8, 2, 0, 0, -1, -1, 4);
        repeat (4) begin
            @(posedge clk); #1;
        end
        run_frame(3, 1, 3, 0, -1, -1, -1);
        check_value("post_reset_pixel", last_pix, 121);

        // Reserved mode behaves as pass.
        run_frame(4, 7, 0, 0, -1, -1, -1);
        check_value("reserved_mode_pixel", last_pix, px[2][1]);

        // Random frames with random bubbles.
        for (int f = 0; f < 12; f++) begin
            run_frame(int'($urandom_range(3, 12)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 1)), 25, -1, -1, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
